// File: rtl/mnist_io_pkg.sv
// Shared definitions for the host file-transfer path.
//   - xfer_state_e : transfer FSM states
//   - tx_phase_e   : per-byte transmit handshake phase
//   - HDR_READ / HDR_WRITE : protocol header bytes
//   - IDX_W        : file index width
package mnist_io_pkg;

    localparam int unsigned IDX_W     = 16;
    localparam logic [7:0]  HDR_READ  = 8'h52;  // 'R'
    localparam logic [7:0]  HDR_WRITE = 8'h57;  // 'W'

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StIdxLo,
        StIdxHi,
        StDataTx,
        StDataRx,
        StFin
    } xfer_state_e;

    // PhPull is the wr_req cycle that fetches a payload byte ahead of its ISSUE phase.
    typedef enum logic [1:0] {
        PhPull,
        PhIssue,
        PhWait
    } tx_phase_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker with a registered priority pointer.
// The pointer starts at NREQ-1 so requester 0 wins the first contest.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req_i       : request vector
//   accept_i    : current pick is taken; pointer moves to it
//   valid_o     : at least one request present
//   pick_o      : one-hot pick (first set bit after the pointer)
//   idx_o       : binary index of the pick
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic            valid_o,
    output logic [NREQ-1:0] pick_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            found;
    logic [NREQ-1:0] pick;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        cand  = '0;
        // Scan from the slot after the pointer; the pointer itself is checked last.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(ptr_q) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
        ptr_d = (accept_i && found) ? idx : ptr_q;
    end

    assign valid_o = found;
    assign pick_o  = pick;
    assign idx_o   = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= IW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/file_xfer_arbiter.sv
// Shares one rs232 byte link between NREQ requesters and runs the host file protocol:
// header 'R'/'W', 16-bit file index LSB first, then len payload bytes.
// Optional macro RX_TIMEOUT_EN: abort a read after TIMEOUT_CYC idle rx cycles (rx_err pulse).
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   req_valid/write/index/len           : per-requester transfer request
//   req_ready, gnt, done                : accept pulse, held grant, completion pulse
//   byte_addr                           : offset of the current payload byte
//   rd_data, rd_valid                   : received payload byte to the granted requester
//   wr_data, wr_req                     : payload byte pull from the granted requester
//   tx_data, tx_en, tx_busy             : rs232 transmit side
//   rx_data, rx_rdy                     : rs232 receive side
//   rx_err                              : rx timeout abort pulse
module file_xfer_arbiter
    import mnist_io_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_write,
    input  logic [NREQ*IDX_W-1:0]   req_index,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [LEN_W-1:0]        byte_addr,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    input  logic [NREQ*8-1:0]       wr_data,
    output logic                    wr_req,
    output logic [7:0]              tx_data,
    output logic                    tx_en,
    input  logic                    tx_busy,
    input  logic [7:0]              rx_data,
    input  logic                    rx_rdy,
    output logic                    rx_err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

    xfer_state_e      state_q, state_d;
    tx_phase_e        phase_q, phase_d;
    logic [NREQ-1:0]  gnt_q, gnt_d, req_ready_q, req_ready_d, done_q, done_d;
    logic [LEN_W-1:0] byte_addr_q, byte_addr_d, len_q, len_d;
    logic [7:0]       rd_data_q, rd_data_d, tx_data_q, tx_data_d;
    logic             rd_valid_q, rd_valid_d, wr_req_q, wr_req_d, tx_en_q, tx_en_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic             last_byte;

    logic             arb_valid, arb_accept;
    logic [NREQ-1:0]  arb_pick;
    logic [IW-1:0]    arb_idx;

`ifdef RX_TIMEOUT_EN
    logic [31:0]      to_cnt_q, to_cnt_d;
    logic             rx_err_q, rx_err_d;
`endif

    assign arb_accept = (state_q == StIdle);

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_valid),
        .accept_i (arb_accept),
        .valid_o  (arb_valid),
        .pick_o   (arb_pick),
        .idx_o    (arb_idx)
    );

    // Never wraps: len is at most 2^LEN_W-1, so byte_addr+1 always fits.
    assign last_byte = ((byte_addr_q + LenOne) == len_q);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        gnt_d       = gnt_q;
        byte_addr_d = byte_addr_q;
        len_d       = len_q;
        rd_data_d   = rd_data_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = tx_en_q;
        write_d     = write_q;
        index_d     = index_q;
        sel_d       = sel_q;
        req_ready_d = '0;
        done_d      = '0;
        rd_valid_d  = 1'b0;
        wr_req_d    = 1'b0;
`ifdef RX_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        rx_err_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt_d       = arb_pick;
                    req_ready_d = arb_pick;
                    sel_d       = arb_idx;
                    write_d     = req_write[arb_idx];
                    index_d     = req_index[32'(arb_idx)*IDX_W +: IDX_W];
                    len_d       = req_len[32'(arb_idx)*LEN_W +: LEN_W];
                    byte_addr_d = '0;
                    tx_data_d   = req_write[arb_idx] ? HDR_WRITE : HDR_READ;
                    tx_en_d     = 1'b1;
                    phase_d     = PhIssue;
                    state_d     = StHead;
                end
            end
            StHead, StIdxLo, StIdxHi, StDataTx: begin
                unique case (phase_q)
                    PhPull: begin
                        tx_data_d = wr_data[32'(sel_q)*8 +: 8];
                        tx_en_d   = 1'b1;
                        phase_d   = PhIssue;
                    end
                    PhIssue: begin
                        if (tx_busy) begin
                            tx_en_d = 1'b0;
                            phase_d = PhWait;
                        end
                    end
                    PhWait: begin
                        if (!tx_busy) begin
                            tx_en_d = 1'b1;
                            phase_d = PhIssue;
                            unique case (state_q)
                                StHead: begin
                                    state_d   = StIdxLo;
                                    tx_data_d = index_q[7:0];
                                end
                                StIdxLo: begin
                                    state_d   = StIdxHi;
                                    tx_data_d = index_q[15:8];
                                end
                                StIdxHi: begin
                                    tx_en_d = 1'b0;
                                    if (len_q == '0) begin
                                        state_d = StFin;
                                        done_d  = gnt_q;
                                    end else if (write_q) begin
                                        state_d  = StDataTx;
                                        phase_d  = PhPull;
                                        wr_req_d = 1'b1;
                                    end else begin
                                        state_d = StDataRx;
`ifdef RX_TIMEOUT_EN
                                        to_cnt_d = '0;
`endif
                                    end
                                end
                                default: begin
                                    tx_en_d     = 1'b0;
                                    byte_addr_d = byte_addr_q + LenOne;
                                    if (last_byte) begin
                                        state_d = StFin;
                                        done_d  = gnt_q;
                                    end else begin
                                        phase_d  = PhPull;
                                        wr_req_d = 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                    default: phase_d = PhIssue;
                endcase
            end
            StDataRx: begin
                // byte_addr advances after the rd_valid cycle so rd_data pairs with its offset.
                if (rd_valid_q) begin
                    byte_addr_d = byte_addr_q + LenOne;
                end
                if (rd_valid_q && last_byte) begin
                    state_d = StFin;
                    done_d  = gnt_q;
                end else if (rx_rdy) begin
                    rd_data_d  = rx_data;
                    rd_valid_d = 1'b1;
                end
`ifdef RX_TIMEOUT_EN
                if (rx_rdy) begin
                    to_cnt_d = '0;
                end else if (state_d == StDataRx) begin
                    if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                        rx_err_d = 1'b1;
                        gnt_d    = '0;
                        state_d  = StIdle;
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end
`endif
            end
            StFin: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            phase_q     <= PhIssue;
            gnt_q       <= '0;
            req_ready_q <= '0;
            done_q      <= '0;
            byte_addr_q <= '0;
            len_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_req_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            write_q     <= 1'b0;
            index_q     <= '0;
            sel_q       <= '0;
`ifdef RX_TIMEOUT_EN
            to_cnt_q    <= '0;
            rx_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            gnt_q       <= gnt_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            byte_addr_q <= byte_addr_d;
            len_q       <= len_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_req_q    <= wr_req_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            write_q     <= write_d;
            index_q     <= index_d;
            sel_q       <= sel_d;
`ifdef RX_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            rx_err_q    <= rx_err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign byte_addr = byte_addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_req    = wr_req_q;
    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;

`ifdef RX_TIMEOUT_EN
    assign rx_err = rx_err_q;
`else
    assign rx_err = 1'b0;
    // TIMEOUT_CYC only has meaning when the rx timeout is compiled in.
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
    end
`endif

endmodule

// File: tb/tb_file_xfer_arbiter.sv
// Self-checking bench for file_xfer_arbiter: emulates the rs232 link and the host,
// and checks transfers against a protocol-level model of expected link bytes and events.
module tb_file_xfer_arbiter;

    localparam int NREQ  = 2;
    localparam int LEN_W = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_write = '0;
    logic [NREQ*16-1:0]    req_index = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [NREQ*8-1:0]     wr_data = '0;
    logic                  tx_busy = 1'b0;
    logic [7:0]            rx_data = '0;
    logic                  rx_rdy = 1'b0;
    logic [NREQ-1:0]       req_ready, gnt, done;
    logic [LEN_W-1:0]      byte_addr;
    logic [7:0]            rd_data, tx_data;
    logic                  rd_valid, wr_req, tx_en, rx_err;

    file_xfer_arbiter #(
        .NREQ        (NREQ),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_index (req_index),
        .req_len   (req_len),
        .req_ready (req_ready),
        .gnt       (gnt),
        .done      (done),
        .byte_addr (byte_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_busy   (tx_busy),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .rx_err    (rx_err)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int proto_errs = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int busy_len = 0;  // 0 selects a random 1..4 cycle busy time
    int rx_rdy_cyc = 0;
    logic [NREQ-1:0] gnt_at_err = '0;
    logic [7:0] tx_log[$];
    logic [7:0] rd_data_log[$];
    int rd_addr_log[$];
    int wr_log[$];
    int rdy_log[$];
    int done_log[$];
    int err_log[$];
    logic [7:0] wr_mem[NREQ][16];
    logic [7:0] pay[16];

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0: return tx_log.size();
            1: return rdy_log.size();
            2: return done_log.size();
            3: return rd_addr_log.size();
            default: return err_log.size();
        endcase
    endfunction

    // Link/host emulator and event monitor, sampled 1 ns after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (tx_busy && tx_en) proto_errs++;
        if ((gnt & (gnt - 1'b1)) != '0) proto_errs++;
        if (req_ready != '0 && req_ready !== gnt) proto_errs++;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end else if (tx_en === 1'b1) begin
            tx_log.push_back(tx_data);
            tx_busy  = 1'b1;
            busy_cnt = (busy_len > 0) ? busy_len : int'($urandom_range(4, 1));
        end
        if (rd_valid === 1'b1) begin
            rd_addr_log.push_back(int'(byte_addr));
            rd_data_log.push_back(rd_data);
        end
        if (wr_req === 1'b1) wr_log.push_back(int'(byte_addr));
        if (req_ready !== '0 && !$isunknown(req_ready)) rdy_log.push_back(oh2i(req_ready));
        if (done !== '0 && !$isunknown(done)) done_log.push_back(oh2i(done));
        if (rx_rdy) rx_rdy_cyc = cyc;
        if (rx_err === 1'b1) begin
            err_log.push_back(cyc);
            gnt_at_err = gnt;
        end
        for (int r = 0; r < NREQ; r++) wr_data[r*8 +: 8] = wr_mem[r][byte_addr[3:0]];
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic clear_logs();
        tx_log.delete();
        rd_data_log.delete();
        rd_addr_log.delete();
        wr_log.delete();
        rdy_log.delete();
        done_log.delete();
        err_log.delete();
        proto_errs = 0;
    endtask

    task automatic wait_for(input string what, input int which, input int n, input int budget);
        int k = 0;
        while (qsize(which) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (qsize(which) < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d events, need %0d", what, qsize(which), n);
        end
    endtask

    // Drive a read up to DATA_RX: request, wait for the 3 header bytes to drain.
    task automatic start_read(input string tag, input int r, input logic [15:0] idx, input int len);
        int k = 0;
        req_write[r] = 1'b0;
        req_index[r*16 +: 16] = idx;
        req_len[r*LEN_W +: LEN_W] = LEN_W'(len);
        req_valid[r] = 1'b1;
        wait_for({tag, " req_ready"}, 1, 1, 50);
        req_valid[r] = 1'b0;
        req_index[r*16 +: 16] = 16'($urandom);
        req_len[r*LEN_W +: LEN_W] = LEN_W'($urandom_range(15, 1));
        req_write[r] = 1'($urandom);
        wait_for({tag, " header"}, 0, 3, 2000);
        while (tx_busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic host_send(input logic [7:0] b);
        repeat ($urandom_range(4, 1)) @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    // One complete transfer scenario with its expected link bytes and events.
    task automatic do_transfer(input string tag, input int r, input bit wr,
                               input logic [15:0] idx, input int len, input int blen);
        logic [7:0] exp_tx[$];
        clear_logs();
        busy_len = blen;
        exp_tx.push_back(wr ? 8'h57 : 8'h52);
        exp_tx.push_back(idx[7:0]);
        exp_tx.push_back(idx[15:8]);
        if (wr) for (int i = 0; i < len; i++) exp_tx.push_back(wr_mem[r][i]);
        if (!wr && len > 0) begin
            start_read(tag, r, idx, len);
            for (int i = 0; i < len; i++) host_send(pay[i]);
        end else begin
            req_write[r] = wr;
            req_index[r*16 +: 16] = idx;
            req_len[r*LEN_W +: LEN_W] = LEN_W'(len);
            req_valid[r] = 1'b1;
            wait_for({tag, " req_ready"}, 1, 1, 50);
            req_valid[r] = 1'b0;
            req_index[r*16 +: 16] = 16'($urandom);
            req_len[r*LEN_W +: LEN_W] = LEN_W'($urandom_range(15, 1));
            req_write[r] = 1'($urandom);
        end
        wait_for({tag, " done"}, 2, 1, 5000);
        repeat (5) @(negedge clk);
        busy_len = 0;

        checks++;
        if (tx_log.size() !== exp_tx.size()) begin
            errors++;
            $display("FAIL %s tx count: got %0d, expected %0d", tag, tx_log.size(), exp_tx.size());
        end else begin
            for (int i = 0; i < exp_tx.size(); i++) begin
                checks++;
                if (tx_log[i] !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL %s tx byte %0d: got %h, expected %h", tag, i, tx_log[i], exp_tx[i]);
                end
            end
        end
        checks++;
        if (rd_addr_log.size() !== (wr ? 0 : len)) begin
            errors++;
            $display("FAIL %s rd_valid count: got %0d, expected %0d", tag, rd_addr_log.size(),
                     wr ? 0 : len);
        end else begin
            for (int i = 0; i < rd_addr_log.size(); i++) begin
                checks++;
                if (rd_addr_log[i] !== i || rd_data_log[i] !== pay[i]) begin
                    errors++;
                    $display("FAIL %s rd byte %0d: got addr %0d data %h, expected addr %0d data %h",
                             tag, i, rd_addr_log[i], rd_data_log[i], i, pay[i]);
                end
            end
        end
        checks++;
        if (wr_log.size() !== (wr ? len : 0)) begin
            errors++;
            $display("FAIL %s wr_req count: got %0d, expected %0d", tag, wr_log.size(), wr ? len : 0);
        end else begin
            for (int i = 0; i < wr_log.size(); i++) begin
                checks++;
                if (wr_log[i] !== i) begin
                    errors++;
                    $display("FAIL %s wr_req addr %0d: got %0d, expected %0d", tag, i, wr_log[i], i);
                end
            end
        end
        checks++;
        if (rdy_log.size() !== 1 || rdy_log[0] !== r) begin
            errors++;
            $display("FAIL %s req_ready: got %0d pulses (first %0d), expected 1 for req %0d", tag,
                     rdy_log.size(), (rdy_log.size() > 0) ? rdy_log[0] : -1, r);
        end
        checks++;
        if (done_log.size() !== 1 || done_log[0] !== r) begin
            errors++;
            $display("FAIL %s done: got %0d pulses (first %0d), expected 1 for req %0d", tag,
                     done_log.size(), (done_log.size() > 0) ? done_log[0] : -1, r);
        end
        checks++;
        if (proto_errs !== 0 || gnt !== '0) begin
            errors++;
            $display("FAIL %s protocol: got %0d violations, gnt %b; expected 0 and 00", tag,
                     proto_errs, gnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (gnt !== '0 || req_ready !== '0 || done !== '0) begin
            errors++;
            $display("FAIL reset handshake: got gnt %b ready %b done %b, expected 0", gnt, req_ready, done);
        end
        checks++;
        if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset tx: got tx_en %b tx_data %h, expected 0", tx_en, tx_data);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || wr_req !== 1'b0 || rx_err !== 1'b0) begin
            errors++;
            $display("FAIL reset data: got rd_valid %b rd_data %h wr_req %b rx_err %b, expected 0",
                     rd_valid, rd_data, wr_req, rx_err);
        end
        checks++;
        if (byte_addr !== '0) begin
            errors++;
            $display("FAIL reset byte_addr: got %0d, expected 0", byte_addr);
        end
    endtask

    task automatic test_single_read();
        pay[0] = 8'hAA;
        pay[1] = 8'hBB;
        pay[2] = 8'hCC;
        do_transfer("single_read", 0, 1'b0, 16'h0021, 3, 0);
    endtask

    task automatic test_single_write();
        wr_mem[1][0] = 8'h5A;
        wr_mem[1][1] = 8'hA5;
        do_transfer("single_write", 1, 1'b1, 16'h0041, 2, 0);
    endtask

    task automatic test_contention();
        int ptr;
        int exp_g;
        logic [15:0] idx_of[NREQ];
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        idx_of[0] = 16'h1234;
        idx_of[1] = 16'h5678;
        req_write = '0;
        req_len = '0;
        req_index = {idx_of[1], idx_of[0]};
        req_valid = '1;
        wait_for("contention req_ready", 1, 4, 3000);
        req_valid = '0;
        wait_for("contention done", 2, 4, 3000);
        repeat (5) @(negedge clk);
        checks++;
        if (rdy_log.size() !== 4 || done_log.size() !== 4 || tx_log.size() !== 12) begin
            errors++;
            $display("FAIL contention counts: got ready %0d done %0d tx %0d, expected 4 4 12",
                     rdy_log.size(), done_log.size(), tx_log.size());
        end else begin
            ptr = NREQ - 1;
            for (int k = 0; k < 4; k++) begin
                exp_g = (ptr + 1) % NREQ;  // both held valid: next after pointer
                ptr = exp_g;
                checks++;
                if (rdy_log[k] !== exp_g || done_log[k] !== exp_g) begin
                    errors++;
                    $display("FAIL contention grant %0d: got ready %0d done %0d, expected %0d",
                             k, rdy_log[k], done_log[k], exp_g);
                end
                checks++;
                if (tx_log[3*k] !== 8'h52 || tx_log[3*k+1] !== idx_of[exp_g][7:0] ||
                    tx_log[3*k+2] !== idx_of[exp_g][15:8]) begin
                    errors++;
                    $display("FAIL contention bytes %0d: got %h %h %h, expected 52 %h %h", k,
                             tx_log[3*k], tx_log[3*k+1], tx_log[3*k+2], idx_of[exp_g][7:0],
                             idx_of[exp_g][15:8]);
                end
            end
        end
        checks++;
        if (proto_errs !== 0) begin
            errors++;
            $display("FAIL contention protocol: got %0d violations, expected 0", proto_errs);
        end
    endtask

    task automatic test_busy();
        for (int i = 0; i < 3; i++) wr_mem[0][i] = 8'($urandom);
        do_transfer("busy50", 0, 1'b1, 16'($urandom), 3, 50);
    endtask

    task automatic test_reset_mid();
        clear_logs();
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        start_read("reset_mid", 0, 16'($urandom), 4);
        host_send(pay[0]);
        wait_for("reset_mid first byte", 3, 1, 50);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({req_ready, gnt, done, byte_addr, rd_data, rd_valid, wr_req, tx_data, tx_en, rx_err} !== '0)
        begin
            errors++;
            $display("FAIL reset_mid outputs: got gnt %b addr %0d rd_data %h tx_en %b, expected all 0",
                     gnt, byte_addr, rd_data, tx_en);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_log.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid done: got %0d pulses, expected 0", done_log.size());
        end
        pay[0] = 8'($urandom);
        do_transfer("restart", 0, 1'b0, 16'($urandom), 1, 0);
    endtask

    task automatic test_random();
        int r;
        int len;
        bit wr;
        for (int t = 0; t < 10; t++) begin
            r   = int'($urandom_range(NREQ - 1, 0));
            wr  = 1'($urandom);
            len = int'($urandom_range(6, 0));
            for (int i = 0; i < 16; i++) begin
                pay[i] = 8'($urandom);
                wr_mem[r][i] = 8'($urandom);
            end
            do_transfer("random", r, wr, 16'($urandom), len, 0);
        end
    endtask

`ifdef RX_TIMEOUT_EN
    task automatic test_timeout();
        clear_logs();
        pay[0] = 8'($urandom);
        start_read("timeout", 0, 16'($urandom), 2);
        host_send(pay[0]);
        wait_for("timeout rx_err", 4, 1, 500);
        repeat (5) @(negedge clk);
        checks++;
        if (err_log.size() !== 1 || err_log[0] - rx_rdy_cyc !== 100 || gnt_at_err !== '0) begin
            errors++;
            $display("FAIL timeout rx_err: got %0d pulses, delay %0d, gnt %b; expected 1, 100, 00",
                     err_log.size(), (err_log.size() > 0) ? err_log[0] - rx_rdy_cyc : -1, gnt_at_err);
        end
        checks++;
        if (done_log.size() !== 0 || rd_addr_log.size() !== 1) begin
            errors++;
            $display("FAIL timeout events: got done %0d rd_valid %0d, expected 0 and 1",
                     done_log.size(), rd_addr_log.size());
        end
    endtask
`endif

    initial begin
        for (int r = 0; r < NREQ; r++) for (int i = 0; i < 16; i++) wr_mem[r][i] = '0;
        for (int i = 0; i < 16; i++) pay[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_busy();
        test_reset_mid();
        test_random();
`ifdef RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/file_xfer_arbiter.md
Name: file_xfer_arbiter

Overview:
- Shares the single rs232 byte link between NREQ datapath requesters, e.g. a conv sequencer and a maxpool sequencer.
- Runs the host file protocol for each transfer: header byte 'R' (0x52) or 'W' (0x57), then the 16-bit file index LSB-first, then the payload bytes.
- Read payload bytes are delivered to the granted requester; write payload bytes are pulled from it.
- Sits between the layer controllers and the rs232 module; replaces the per-layer IO states.

Parameters:
- NREQ, 2, number of requesters.
- LEN_W, 16, width of the byte count and byte offset.
- TIMEOUT_CYC, 1000000, rx idle limit in clk cycles; used only with RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  transfer request pending, one bit per requester
- req_write  in  NREQ  1 = write file (W), 0 = read file (R)
- req_index  in  NREQ*16  file index; slice i belongs to requester i
- req_len  in  NREQ*LEN_W  payload byte count
- req_ready  out  NREQ  one-cycle accept pulse; request fields are captured on this cycle
- gnt  out  NREQ  one-hot; held for the whole transfer
- done  out  NREQ  one-cycle completion pulse
- byte_addr  out  LEN_W  offset of the current payload byte (0..len-1)
- rd_data  out  8  received payload byte
- rd_valid  out  1  rd_data valid, one cycle
- wr_data  in  NREQ*8  payload byte from each requester; muxed by gnt
- wr_req  out  1  one-cycle pull strobe; wr_data is sampled in the same cycle
- tx_data  out  8  byte to rs232
- tx_en  out  1  transmit request
- tx_busy  in  1  rs232 transmitter busy
- rx_data  in  8  received byte
- rx_rdy  in  1  one-cycle pulse per received byte
- rx_err  out  1  timeout abort pulse; constant 0 without RX_TIMEOUT_EN

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = NREQ-1, so requester 0 wins first. Reset mid-transfer aborts it: no done pulse, and tx_en drops at that edge.
- States: IDLE, HEAD, IDX_LO, IDX_HI, DATA_TX, DATA_RX, FIN.
- Each transmit state has two phases:
  - ISSUE: tx_en=1 with tx_data stable; move to WAIT on tx_busy=1.
  - WAIT: tx_en=0; advance on tx_busy=0.
- IDLE:
  - If any req_valid in cycle N, pick the first set bit after the pointer (round-robin).
  - At edge N+1: gnt, req_ready pulse, latched write/index/len, byte_addr=0, state HEAD, pointer updated.
  - tx_en first asserts in cycle N+1.
- HEAD sends 0x52 or 0x57, then IDX_LO sends index[7:0], then IDX_HI sends index[15:8].
- After IDX_HI:
  - len==0 goes to FIN.
  - Otherwise a write goes to DATA_TX and a read goes to DATA_RX.
- DATA_TX:
  - At entry to each ISSUE phase, wr_req pulses for one cycle and wr_data[gnt] is registered into tx_data.
  - byte_addr increments after each WAIT completes.
  - After byte len-1 completes, go to FIN.
- DATA_RX:
  - Each rx_rdy captures rx_data into rd_data, pulses rd_valid at the next edge, and increments byte_addr.
  - After the len-th byte, go to FIN.
  - rx_rdy in any other state is ignored.
- FIN: done[gnt] pulses for one cycle, gnt clears, return to IDLE.
  - The next arbitration decision is taken in the cycle after FIN, so there is no back-to-back grant in the FIN cycle.
- Request lines:
  - Changes to req_* during a transfer are ignored.
  - A requester that drops req_valid before grant is simply not granted.
- byte_addr width: len up to 2^LEN_W-1. The counter never wraps, because the transfer ends at len.
- Simultaneous requests: strict round-robin. With both requesters held valid, grants alternate 0,1,0,1.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - A counter resets on each rx_rdy and on DATA_RX entry.
  - Reaching TIMEOUT_CYC-1 in DATA_RX pulses rx_err for one cycle, clears gnt without a done pulse, and returns to IDLE.
  - The pointer advances normally.
- Undefined: no counter logic; rx_err is tied to 0 and DATA_RX waits indefinitely.

Decomposition:
- Shared package (mnist_io_pkg) holds:
  - state enum;
  - constants HDR_READ=8'h52 and HDR_WRITE=8'h57;
  - file index width 16.
- One natural sub-module: rr_arbiter (NREQ-bit round-robin pick with pointer update on accept), reusable for later memory-port arbitration.

Test Plan:
- Single read: req0 with write=0, index=16'h0021, len=3, host returns AA,BB,CC.
  - Link sends 52,21,00.
  - rd_valid pulses three times with AA/BB/CC at byte_addr 0/1/2, then done[0].
- Single write: req1 with write=1, index=16'h0041, len=2, wr_data=5A then A5.
  - Link sends 57,41,00,5A,A5.
  - Exactly two wr_req pulses, then done[1].
- Contention: req0 and req1 both held, len=0.
  - Grant order after reset is 0,1,0,1.
  - Each transfer sends exactly 3 bytes, and req_ready and done each pulse once per grant.
- tx_busy handshake: tx_busy held high for 50 cycles after each tx_en.
  - tx_en drops once tx_busy=1, and no byte is duplicated or skipped.
- Reset mid-DATA_RX after 1 of 4 bytes: all outputs return to 0, with no done.
  - A new req0 restarts the header from 0x52.
- With RX_TIMEOUT_EN and TIMEOUT_CYC=100: read len=2, host sends 1 byte then stops.
  - rx_err pulses 100 cycles after that byte, gnt clears, no done.
